multi_byte_add_sequencer: RTL and testbench
===========================================

Name: multi_byte_add_sequencer

Overview:
- Sequences multi-precision add/subtract over one internal eight_bit_select_adder instance. Operands are processed one byte at a time, least-significant byte first, and each byte's carry-out is chained into the next byte's carry-in.
- Issues a new byte every 2 cycles, overlapping the 3-cycle adder pipeline with the carry dependency.
- Sits between a requester (valid/ready request channel) and a consumer (valid/ready response channel).

Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..16.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_a  in  8*NBYTES  operand A
- req_b  in  8*NBYTES  operand B
- req_cin  in  1  carry-in for add; ignored when req_sub=1
- req_sub  in  1  1 = A - B (A + ~B + 1)
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  8*NBYTES  result
- rsp_cout  out  1  final carry-out (for sub: 1 = no borrow)
- rsp_ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, all operand, byte-counter and carry registers cleared. The internal adder shares reset_n.
- Adder timing contract, with k = cycle in which A/B are driven to the adder:
  - A/B are captured at the end of cycle k.
  - Cin must be valid during cycle k+1; it is consumed combinationally.
  - Sum and Cout are valid during cycle k+3.
- FSM states: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid, latch A, latch B' = req_sub ? ~req_b : req_b, latch cin0 = req_sub ? 1 : req_cin, and latch the sub flag. Go to RUN; the next cycle is c0.
- RUN, byte k (0..NBYTES-1):
  - Drive adder A/B with byte k in cycle c(2k). In all other cycles drive 0; these values are don't-care.
  - Cin during c1 = latched cin0.
  - Cin during c(2k+1), k>=1 = adder Cout observed in that same cycle, which is byte k-1's carry.
  - Capture adder sum into result byte k at the end of c(2k+3).
  - At the end of c(2*NBYTES+1), capture the last Cout into rsp_cout and go to DONE.
- DONE: rsp_valid=1. rsp_sum, rsp_cout and rsp_ovf are stable until handshake.
  - rsp_ovf = (A[msb] == B'[msb]) && (sum[msb] != A[msb]).
  - On rsp_ready, go to IDLE; rsp_valid deasserts the next cycle.
- Latency: rsp_valid first high in cycle c(2*NBYTES+2), i.e. 2*NBYTES+3 cycles after the acceptance edge. For NBYTES=4 this is 11 cycles.
- req_ready is 0 in RUN and DONE. A request arriving then is held by the requester and is not lost. There is no accept in the same cycle as a DONE handshake.
- Minimum request spacing: 2*NBYTES+4 cycles with rsp_ready tied high.
- Byte counter spans 0..2*NBYTES+1 and needs no wrap handling; it is cleared on entry to RUN.
- Inputs req_a, req_b, req_cin and req_sub are sampled only at acceptance. Later changes have no effect.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. The partially computed result is discarded, and the adder pipeline is cleared by the same reset.
- The Cout from an adder-output cycle carrying no valid byte is never used as Cin.

Test Plan:
- Add with full carry propagation, NBYTES=4: A=0xFFFFFFFF, B=0x00000001, cin=0 -> rsp_sum=0x00000000, rsp_cout=1, rsp_ovf=0. rsp_valid is first high exactly 11 cycles after acceptance.
- Subtract with borrow: A=0x00000005, B=0x00000007, sub=1 -> rsp_sum=0xFFFFFFFE, rsp_cout=0, rsp_ovf=0. Then A=7, B=5, sub=1 -> rsp_sum=0x00000002, rsp_cout=1.
- Signed overflow and carry-in:
  - A=0x7FFFFFFF, B=0x00000000, cin=1 -> rsp_sum=0x80000000, rsp_ovf=1, rsp_cout=0.
  - A=0x80000000, B=0x80000000 -> rsp_sum=0, rsp_cout=1, rsp_ovf=1.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid -> sum stable, req_ready=0, and a pending request is not accepted. Raise rsp_ready -> the next request is accepted 1 cycle after the handshake, and its result is correct.
- Reset mid-operation: assert reset_n=0 in c3 of A=0x12345678 + B=0x11111111 -> all outputs 0, req_ready=1. A new request A=0x01020304 + B=0x10203040 -> rsp_sum=0x11223344, with no corruption from the aborted op.
- Random regression: 1000 random A/B/cin/sub requests with random rsp_ready stalls -> every result matches the reference model (sum, cout, ovf).

Source files
------------

// File: rtl/multi_byte_add_sequencer.sv
// rtl/multi_byte_add_sequencer.sv - multi-precision add/sub sequenced byte-serially over a pipelined 8-bit adder
// The adder captures A/B at the end of cycle k, takes Cin in k+1 and presents Sum/Cout in k+3.

module eight_bit_select_adder (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic [7:0] r_a, r_b;
  logic [8:0] r_s2, r_s3;
  logic [4:0] w_lo;
  logic [4:0] w_hi0, w_hi1, w_hi;

  // Late-arriving Cin only ripples through the low nibble; the high nibble is pre-computed both ways.
  assign w_lo  = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, i_cin};
  assign w_hi0 = {1'b0, r_a[7:4]} + {1'b0, r_b[7:4]};
  assign w_hi1 = {1'b0, r_a[7:4]} + {1'b0, r_b[7:4]} + 5'd1;
  assign w_hi  = w_lo[4] ? w_hi1 : w_hi0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_a  <= i_a;
      r_b  <= i_b;
      r_s2 <= {w_hi, w_lo[3:0]};
      r_s3 <= r_s2;
    end
  end

  assign o_sum  = r_s3[7:0];
  assign o_cout = r_s3[8];
endmodule

module multi_byte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  input  logic                req_cin,
  input  logic                req_sub,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_sum,
  output logic                rsp_cout,
  output logic                rsp_ovf
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(2 * NBYTES + 2);
  localparam logic [CW-1:0] LAST = CW'(2 * NBYTES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a, r_b, r_sum;
  logic          r_cin0;
  logic [CW-1:0] r_cnt;
  logic          r_req_ready, r_rsp_valid, r_cout, r_ovf;

  logic [CW-2:0] w_rd_idx, w_wr_idx;
  logic [7:0]    w_add_a, w_add_b, w_add_sum;
  logic          w_add_cin, w_add_cout, w_drive, w_cap;

  assign w_rd_idx = r_cnt[CW-1:1];
  assign w_wr_idx = r_cnt[CW-1:1] - 1'b1;
  assign w_drive  = (r_state == RUN) && !r_cnt[0];
  assign w_cap    = (r_state == RUN) && r_cnt[0] && (r_cnt >= CW'(3));

  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (w_drive && w_rd_idx == (CW-1)'(i)) begin
        w_add_a = r_a[i*8 +: 8];
        w_add_b = r_b[i*8 +: 8];
      end
    end
  end

  // Chain only carries that belong to a real byte: c1 takes cin0, c3..c(2N-1) take the previous byte's Cout.
  always_comb begin
    w_add_cin = 1'b0;
    if (r_state == RUN) begin
      if (r_cnt == CW'(1))
        w_add_cin = r_cin0;
      else if (r_cnt[0] && r_cnt >= CW'(3) && r_cnt <= LAST - CW'(2))
        w_add_cin = w_add_cout;
    end
  end

  eight_bit_select_adder u_adder (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_a       (w_add_a),
    .i_b       (w_add_b),
    .i_cin     (w_add_cin),
    .o_sum     (w_add_sum),
    .o_cout    (w_add_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cin0      <= 1'b0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a         <= req_a;
            r_b         <= req_sub ? ~req_b : req_b;
            r_cin0      <= req_sub ? 1'b1 : req_cin;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          for (int i = 0; i < NBYTES; i++) begin
            if (w_cap && w_wr_idx == (CW-1)'(i))
              r_sum[i*8 +: 8] <= w_add_sum;
          end
          if (r_cnt == LAST) begin
            r_cout      <= w_add_cout;
            r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_add_sum[7] != r_a[W-1]);
            r_rsp_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_ovf   = r_ovf;
endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// tb/tb_multi_byte_add_sequencer.sv - directed and random checks of multi_byte_add_sequencer (NBYTES=4)

module tb_multi_byte_add_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_cin, req_sub;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
  logic [31:0] rsp_sum;

  int n_vec = 0;
  int n_err = 0;

  multi_byte_add_sequencer #(.NBYTES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    bit ok = 0;
    req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom); req_sub = 1'($urandom);
  endtask

  // Called #1 after the acceptance edge; returns #1 after the response handshake edge.
  task automatic get_rsp(input logic [31:0] es, input logic ec, input logic eo,
                         input bit rand_ready, input bit chk_lat);
    int n = 1;
    int first = 0;
    bit done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (rsp_valid && first == 0) first = n;
      if (rsp_valid && rsp_ready) begin
        chk("sum", rsp_sum, es);
        chk("cout", {31'd0, rsp_cout}, {31'd0, ec});
        chk("ovf", {31'd0, rsp_ovf}, {31'd0, eo});
        done = 1;
      end
      @(posedge clk); #1;
      n++;
      if (rand_ready && !done) rsp_ready = 1'($urandom_range(0, 1));
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    else chk("valid_drop", {31'd0, rsp_valid}, 32'd0);
    if (chk_lat) chk("latency", 32'(first), 32'd11);
    rsp_ready = 1'b1;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                     input logic [31:0] es, input logic ec, input logic eo);
    accept(a, b, cin, sub);
    get_rsp(es, ec, eo, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] a, b, bp, es;
    logic        cin, sub, c0, ec, eo;
    logic [32:0] full;
    bit          seen;

    reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
    req_cin = 1'b0; req_sub = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_sum", rsp_sum, 32'd0);
    chk("rst_cout_ovf", {30'd0, rsp_cout, rsp_ovf}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Backpressure with a pending request held during DONE
    rsp_ready = 1'b0;
    accept(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = rsp_valid;
      if (!seen) begin @(posedge clk); #1; end
    end
    if (!seen) chk("bp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_a = 32'hAAAA_AAAA; req_b = 32'h5555_5555; req_cin = 1'b1; req_sub = 1'b0; req_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("bp_sum", rsp_sum, 32'h0001_0000);
      chk("bp_valid_ready", {30'd0, rsp_valid, req_ready}, 32'd2);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_hs", {30'd0, rsp_valid, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 32'h1234_5678; req_b = 32'h0;
    get_rsp(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in c3 of an operation
    accept(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_sum", rsp_sum, 32'd0);
    chk("mid_rst_flags", {28'd0, rsp_valid, rsp_cout, rsp_ovf, req_ready}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0, 32'h1122_3344, 1'b0, 1'b0);

    for (int v = 0; v < 1000; v++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      bp   = sub ? ~b : b;
      c0   = sub ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, bp} + {32'd0, c0};
      es   = full[31:0];
      ec   = full[32];
      eo   = (a[31] == bp[31]) && (es[31] != a[31]);
      rsp_ready = 1'($urandom_range(0, 1));
      accept(a, b, cin, sub);
      get_rsp(es, ec, eo, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
